// File: rtl/io_fifo_defs.sv
// rtl/io_fifo_defs.sv - register offsets, STATUS layout and bus FSM states for io_fifo_port
package io_fifo_defs;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int STAT_RX_NONEMPTY = 0;
  localparam int STAT_TX_FULL     = 1;
  localparam int STAT_RX_OVR      = 2;
  localparam int STAT_TX_OVR      = 3;
  localparam int STAT_TX_EMPTY    = 4;
  localparam int STAT_RX_COUNT    = 8;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_CLR_OVR = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } bus_state_e;

  function automatic logic [15:0] pack_status(
    input logic       rx_nonempty,
    input logic       tx_full,
    input logic       rx_ovr,
    input logic       tx_ovr,
    input logic       tx_empty,
    input logic [4:0] rx_count
  );
    logic [15:0] s;
    s = '0;
    s[STAT_RX_NONEMPTY] = rx_nonempty;
    s[STAT_TX_FULL]     = tx_full;
    s[STAT_RX_OVR]      = rx_ovr;
    s[STAT_TX_OVR]      = tx_ovr;
    s[STAT_TX_EMPTY]    = tx_empty;
    s[STAT_RX_COUNT +: 5] = rx_count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push at full succeeds when a pop happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_fifo_port.sv
// rtl/io_fifo_port.sv - I/O-mapped RX/TX FIFO port with wait-state bus handshake and open-drain irq
module io_fifo_port
  import io_fifo_defs::*;
#(
  parameter logic [7:0] BASE        = 8'h10,
  parameter int         WAIT_STATES = 2,
  parameter int         DEPTH       = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        nio,
  input  logic        nsysdev,
  input  logic        nr,
  input  logic        nw,
  input  logic [7:0]  ab,
  inout  wire  [15:0] db,
  inout  wire         nws,
  output wire         nirq,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  bus_state_e      state, state_nxt;
  logic [2:0]      wait_cnt;
  logic            bus_armed;
  logic            cap_wr;
  logic [1:0]      cap_off;
  logic            cap_pop;
  logic [15:0]     rd_data;
  logic [15:0]     rd_mux;
  logic            irq_en, rx_ovr, tx_ovr;

  logic            sel, capture, act;
  logic            rx_pop, tx_push, ctrl_wr, rx_drop, tx_drop;
  logic [15:0]     rx_head;
  logic            rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0]   rx_count, tx_count;

  // bus_armed stays low after reset until both strobes have been seen high.
  assign sel     = bus_armed & ~nio & ~nsysdev & (ab[7:2] == BASE[7:2]) & (~nr ^ ~nw);
  assign capture = (state == S_IDLE) & sel;
  assign act     = (state == S_ACTIVE);
  assign rx_pop  = act & ~cap_wr & (cap_off == OFF_DATA) & cap_pop;
  assign tx_push = act & cap_wr & (cap_off == OFF_DATA);
  assign ctrl_wr = act & cap_wr & (cap_off == OFF_CTRL);
  assign rx_drop = rx_valid & rx_full & ~rx_pop;
  assign tx_drop = tx_push & tx_full & ~tx_ready;

  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .nreset(nreset), .push(rx_valid), .push_data(rx_data), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .nreset(nreset), .push(tx_push), .push_data(db), .pop(tx_ready),
    .head(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  always_comb begin
    rd_mux = '0;
    case (ab[1:0])
      OFF_DATA:   rd_mux = rx_empty ? 16'h0000 : rx_head;
      OFF_STATUS: rd_mux = pack_status(~rx_empty, tx_full, rx_ovr, tx_ovr, tx_empty, 5'(rx_count));
      OFF_CTRL:   rd_mux = {15'b0, irq_en};
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sel) state_nxt = (WAIT_STATES == 0) ? S_ACTIVE : S_WAIT;
      S_WAIT:   if (wait_cnt == 3'(WAIT_STATES - 1)) state_nxt = S_ACTIVE;
      S_ACTIVE: state_nxt = S_DONE;
      S_DONE:   if (nr & nw) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      bus_armed <= 1'b0;
      cap_wr    <= 1'b0;
      cap_off   <= '0;
      cap_pop   <= 1'b0;
      rd_data   <= '0;
      irq_en    <= 1'b0;
      rx_ovr    <= 1'b0;
      tx_ovr    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == S_WAIT && state_nxt == S_WAIT) ? wait_cnt + 3'd1 : 3'd0;
      if (nr & nw) bus_armed <= 1'b1;
      // Snapshot the read value and whether it came from a real RX entry.
      if (capture) begin
        cap_wr  <= ~nw;
        cap_off <= ab[1:0];
        cap_pop <= ~rx_empty;
        rd_data <= rd_mux;
      end
      if (ctrl_wr) irq_en <= db[CTRL_IRQ_EN];
      if (ctrl_wr && db[CTRL_CLR_OVR]) begin
        rx_ovr <= 1'b0;
        tx_ovr <= 1'b0;
      end
      if (rx_drop) rx_ovr <= 1'b1;
      if (tx_drop) tx_ovr <= 1'b1;
    end
  end

  assign db   = (state != S_IDLE && !cap_wr && !nr) ? rd_data : {16{1'bz}};
  assign nws  = (state == S_WAIT) ? 1'b0 : 1'bz;
  assign nirq = (irq_en & (~rx_empty | rx_ovr)) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_io_fifo_port.sv
// tb/tb_io_fifo_port.sv - self-checking bench for io_fifo_port
module tb_io_fifo_port;

  localparam logic [7:0] BASE  = 8'h10;
  localparam int         WS    = 2;
  localparam int         DEPTH = 16;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic nio = 1'b1, nsysdev = 1'b1, nr = 1'b1, nw = 1'b1;
  logic [7:0] ab = 8'h00;
  tri1 [15:0] db;
  tri1 nws;
  tri1 nirq;
  logic tb_oe = 1'b0;
  logic [15:0] tb_db = 16'h0000;
  logic [15:0] rx_data = 16'h0000;
  logic rx_valid = 1'b0;
  logic rx_ready;
  logic [15:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_rxq[$];
  logic [15:0] m_txq[$];
  bit m_rx_ovr, m_tx_ovr, m_irq_en;

  typedef struct {
    bit          wr;
    logic [1:0]  off;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[12];

  assign db = tb_oe ? tb_db : 16'hzzzz;
  always #5 clk = ~clk;

  io_fifo_port #(.BASE(BASE), .WAIT_STATES(WS), .DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset), .nio(nio), .nsysdev(nsysdev), .nr(nr), .nw(nw),
    .ab(ab), .db(db), .nws(nws), .nirq(nirq),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0; nr = 1'b1; nw = 1'b1; nio = 1'b1; nsysdev = 1'b1;
    tb_oe = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    m_rxq.delete(); m_txq.delete();
    m_rx_ovr = 0; m_tx_ovr = 0; m_irq_en = 0;
  endtask

  task automatic bus_xfer(input bit wr, input logic [1:0] off, input logic [15:0] wdata,
                          input int hold, output logic [15:0] rdata, output int nws_low);
    @(negedge clk);
    nio = 1'b0; nsysdev = 1'b0; ab = {BASE[7:2], off};
    if (wr) begin
      tb_db = wdata; tb_oe = 1'b1; nw = 1'b0;
    end else begin
      nr = 1'b0;
    end
    nws_low = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (nws == 1'b0) nws_low++;
    end
    rdata = db;
    @(negedge clk);
    nr = 1'b1; nw = 1'b1; tb_oe = 1'b0; nio = 1'b1; nsysdev = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic dev_step(input bit v, input logic [15:0] d, input bit r);
    @(negedge clk);
    rx_valid = v; rx_data = d; tx_ready = r;
    @(posedge clk); #1;
    rx_valid = 1'b0; tx_ready = 1'b0;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[0] = (m_rxq.size() != 0);
    s[1] = (m_txq.size() == DEPTH);
    s[2] = m_rx_ovr;
    s[3] = m_tx_ovr;
    s[4] = (m_txq.size() == 0);
    s[12:8] = 5'(m_rxq.size());
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int nl;
    int op;
    logic [1:0] off;
    logic [15:0] d, e;
    bit v, r;

    vecs[0]  = '{0, 2'd1, 16'h0000, 16'h0010};
    vecs[1]  = '{0, 2'd2, 16'h0000, 16'h0000};
    vecs[2]  = '{1, 2'd2, 16'h0001, 16'h0000};
    vecs[3]  = '{0, 2'd2, 16'h0000, 16'h0001};
    vecs[4]  = '{0, 2'd3, 16'h0000, 16'h0000};
    vecs[5]  = '{1, 2'd3, 16'hFFFF, 16'h0000};
    vecs[6]  = '{0, 2'd3, 16'h0000, 16'h0000};
    vecs[7]  = '{0, 2'd2, 16'h0000, 16'h0001};
    vecs[8]  = '{1, 2'd2, 16'hFFFC, 16'h0000};
    vecs[9]  = '{0, 2'd2, 16'h0000, 16'h0000};
    vecs[10] = '{0, 2'd0, 16'h0000, 16'h0000};
    vecs[11] = '{0, 2'd1, 16'h0000, 16'h0010};

    do_reset();
    @(posedge clk); #1;
    chk("reset_nws", nws, 1'b1);
    chk("reset_nirq", nirq, 1'b1);
    chk("reset_db", db, 16'hFFFF);
    chk("reset_rx_ready", rx_ready, 1'b1);
    chk("reset_tx_valid", tx_valid, 1'b0);

    for (int i = 0; i < 12; i++) begin
      bus_xfer(vecs[i].wr, vecs[i].off, vecs[i].wdata, WS + 4, rd, nl);
      chk($sformatf("vec%0d_nws", i), nl, WS);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
    end

    // Bus write into TX, then device drains it.
    do_reset();
    bus_xfer(1, 2'd0, 16'hBEEF, WS + 4, rd, nl);
    chk("beef_nws_edges", nl, 2);
    chk("beef_tx_valid", tx_valid, 1'b1);
    chk("beef_tx_data", tx_data, 16'hBEEF);
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("beef_status", rd, 16'h0000);
    dev_step(0, 16'h0, 1);
    chk("beef_drained", tx_valid, 1'b0);

    dev_step(1, 16'h1234, 0);
    dev_step(1, 16'h5678, 0);
    bus_xfer(0, 2'd0, 16'h0, WS + 4, rd, nl);
    chk("rx_rd1", rd, 16'h1234);
    bus_xfer(0, 2'd0, 16'h0, WS + 4, rd, nl);
    chk("rx_rd2", rd, 16'h5678);
    bus_xfer(0, 2'd0, 16'h0, WS + 4, rd, nl);
    chk("rx_rd_empty", rd, 16'h0000);
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("rx_empty_status", rd, 16'h0010);

    // RX overflow, clear, then a pop coinciding with a push at full.
    do_reset();
    for (int i = 0; i < 16; i++) dev_step(1, 16'hA000 + 16'(i), 0);
    chk("full_rx_ready", rx_ready, 1'b0);
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("full_status", rd, 16'h1011);
    dev_step(1, 16'hDEAD, 0);
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("ovr_status", rd, 16'h1015);
    bus_xfer(1, 2'd2, 16'h0002, WS + 4, rd, nl);
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("ovr_cleared", rd, 16'h1011);
    @(negedge clk); rx_valid = 1'b1; rx_data = 16'hCAFE;
    bus_xfer(0, 2'd0, 16'h0, WS + 4, rd, nl);
    rx_valid = 1'b0;
    chk("full_pop_push_rd", rd, 16'hA000);
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("full_pop_push_status", rd, 16'h1015);
    for (int i = 1; i <= 16; i++) begin
      bus_xfer(0, 2'd0, 16'h0, WS + 4, rd, nl);
      chk($sformatf("drain%0d", i), rd, (i == 16) ? 16'hCAFE : 16'hA000 + 16'(i));
    end

    // Interrupt follows rx_nonempty when enabled.
    do_reset();
    bus_xfer(1, 2'd2, 16'h0001, WS + 4, rd, nl);
    chk("irq_idle", nirq, 1'b1);
    dev_step(1, 16'h0042, 0);
    chk("irq_asserted", nirq, 1'b0);
    bus_xfer(0, 2'd0, 16'h0, WS + 4, rd, nl);
    chk("irq_rd", rd, 16'h0042);
    chk("irq_released", nirq, 1'b1);

    // Both strobes low is not a selection; long strobe pops once.
    do_reset();
    for (int i = 1; i <= 3; i++) dev_step(1, 16'h0300 + 16'(i), 0);
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("three_status", rd, 16'h0311);
    @(negedge clk);
    nio = 1'b0; nsysdev = 1'b0; ab = BASE; nr = 1'b0; nw = 1'b0;
    nl = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (nws == 1'b0) nl++;
    end
    @(negedge clk); nr = 1'b1; nw = 1'b1; nio = 1'b1; nsysdev = 1'b1;
    chk("both_strobes_nws", nl, 0);
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("both_strobes_status", rd, 16'h0311);
    bus_xfer(0, 2'd0, 16'h0, 10, rd, nl);
    chk("long_rd", rd, 16'h0301);
    chk("long_rd_nws", nl, WS);
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("long_rd_status", rd, 16'h0211);

    // Reset asserted while the port is holding wait.
    do_reset();
    dev_step(1, 16'h0777, 0);
    @(negedge clk);
    nio = 1'b0; nsysdev = 1'b0; ab = {BASE[7:2], 2'd1}; nr = 1'b0;
    @(posedge clk); #1;
    chk("midrst_wait_nws", nws, 1'b0);
    chk("midrst_wait_db", db, 16'h0111);
    nreset = 1'b0; #1;
    chk("midrst_nws", nws, 1'b1);
    chk("midrst_db", db, 16'hFFFF);
    @(negedge clk); nreset = 1'b1;
    nl = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (nws == 1'b0) nl++;
    end
    chk("midrst_strobe_ignored", nl, 0);
    chk("midrst_db_after", db, 16'hFFFF);
    @(negedge clk); nr = 1'b1; nio = 1'b1; nsysdev = 1'b1;
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("midrst_status", rd, 16'h0010);

    // Randomized traffic against the queue model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 7);
      d  = 16'($urandom);
      case (op)
        0, 1, 2, 7: begin
          v = ($urandom_range(0, 3) != 0);
          r = (op == 7) ? 1'b1 : ($urandom_range(0, 3) == 0);
          @(negedge clk);
          rx_valid = v; rx_data = d; tx_ready = r;
          #1;
          chk("rnd_rx_ready", rx_ready, m_rxq.size() < DEPTH);
          chk("rnd_tx_valid", tx_valid, m_txq.size() != 0);
          if (m_txq.size() != 0) chk("rnd_tx_data", tx_data, m_txq[0]);
          chk("rnd_nirq", nirq, !(m_irq_en && (m_rxq.size() != 0 || m_rx_ovr)));
          @(posedge clk); #1;
          rx_valid = 1'b0; tx_ready = 1'b0;
          if (r && m_txq.size() != 0) void'(m_txq.pop_front());
          if (v) begin
            if (m_rxq.size() < DEPTH) m_rxq.push_back(d);
            else m_rx_ovr = 1;
          end
        end
        3: begin
          e = (m_rxq.size() != 0) ? m_rxq.pop_front() : 16'h0000;
          bus_xfer(0, 2'd0, 16'h0, WS + 4, rd, nl);
          chk("rnd_data_rd", rd, e);
          chk("rnd_nws", nl, WS);
        end
        4: begin
          off = 2'($urandom_range(1, 3));
          e = (off == 2'd1) ? m_status() : (off == 2'd2) ? {15'b0, m_irq_en} : 16'h0000;
          bus_xfer(0, off, 16'h0, WS + 4, rd, nl);
          chk($sformatf("rnd_reg_rd%0d", off), rd, e);
        end
        5: begin
          bus_xfer(1, 2'd0, d, WS + 4, rd, nl);
          if (m_txq.size() < DEPTH) m_txq.push_back(d);
          else m_tx_ovr = 1;
        end
        default: begin
          d = {14'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
          bus_xfer(1, 2'd2, d, WS + 4, rd, nl);
          m_irq_en = d[0];
          if (d[1]) begin
            m_rx_ovr = 0;
            m_tx_ovr = 0;
          end
        end
      endcase
    end
    bus_xfer(0, 2'd1, 16'h0, WS + 4, rd, nl);
    chk("rnd_final_status", rd, m_status());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
